packet_framer: RTL

- Byte-serial successor to the fixed 3-byte packet decoder.
- Takes bytes from the UART receiver one strobe at a time and frames packets as SOF, PAYLOAD_BYTES data bytes, optional checksum, then EOF.
- Commits valid payloads to registered outputs and decodes motion fields from payload byte 0.
- Adds inter-byte timeout, error counting, and a link watchdog that stops the car (xDir/yDir forced to 0) when valid packets stop arriving.

---
 rtl/packet_pkg.sv | 28 ++
 rtl/link_watchdog.sv | 40 ++++
 rtl/packet_framer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/packet_pkg.sv
// Shared definitions for packet_framer: FSM state encoding, default frame
// delimiters, motion-field slice positions and a saturating increment helper.
package packet_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_TRAILER = 2'd3
    } state_e;

    localparam logic [7:0] DEFAULT_SOF = 8'hFF;
    localparam logic [7:0] DEFAULT_EOF = 8'hFF;

    // Motion fields inside payload byte 0
    localparam int XDIR_LSB = 0;
    localparam int XDIR_W   = 2;
    localparam int YDIR_LSB = 2;
    localparam int YDIR_W   = 2;
    localparam int ADD_LSB  = 4;
    localparam int ADD_W    = 4;

    // Error counter increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/link_watchdog.sv
// Link watchdog: counts cycles since the last clear and saturates at LIMIT.
// expired_o is high while the count sits at LIMIT.
module link_watchdog #(
    parameter int unsigned LIMIT = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic expired_o
);

    localparam int W = $clog2(LIMIT) + 1;
    localparam logic [W-1:0] CNT_MAX = W'(LIMIT);
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise climb until the limit and hold there
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/packet_framer.sv
// Byte-serial packet framer: SOF, PAYLOAD_BYTES data bytes, optional XOR
// checksum, EOF. Good frames are committed to registered outputs; bad frames
// and inter-byte timeouts pulse frame_err and bump a saturating err_count.
// A link watchdog drops link_ok and zeroes xDir/yDir when commits stop.
// Optional checksum stage: define PACKET_FRAMER_CHECKSUM_EN.
//
// Handshake: rx_byte is consumed on every cycle rx_valid=1 (no backpressure);
// payload_valid and frame_err are single-cycle pulses on the cycle after the
// deciding byte (or the timeout) was seen.
module packet_framer
    import packet_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES   = 1,
    parameter logic [7:0]  SOF_BYTE        = DEFAULT_SOF,
    parameter logic [7:0]  EOF_BYTE        = DEFAULT_EOF,
    parameter int unsigned TIMEOUT_CYCLES  = 50000,
    parameter int unsigned WATCHDOG_CYCLES = 5000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 rx_byte,
    input  logic                       rx_valid,
    output logic [8*PAYLOAD_BYTES-1:0] payload,
    output logic                       payload_valid,
    output logic [1:0]                 xDir,
    output logic [1:0]                 yDir,
    output logic [3:0]                 additionalData,
    output logic                       link_ok,
    output logic                       frame_err,
    output logic [7:0]                 err_count,
    output logic [1:0]                 state_o
);

    localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

`ifdef PACKET_FRAMER_CHECKSUM_EN
    localparam state_e AFTER_PAYLOAD = ST_CHECK;
`else
    localparam state_e AFTER_PAYLOAD = ST_TRAILER;
`endif

    state_e                     state_q;
    logic [IDX_W-1:0]           idx_q;
    logic [8*PAYLOAD_BYTES-1:0] shadow_q;
    logic [8*PAYLOAD_BYTES-1:0] payload_q;
    logic                       pv_q;
    logic [1:0]                 x_q;
    logic [1:0]                 y_q;
    logic [3:0]                 ad_q;
    logic                       link_q;
    logic                       fe_q;
    logic [7:0]                 ec_q;
    logic [TO_W-1:0]            idle_q;
    logic [TO_W-1:0]            idle_d;
`ifdef PACKET_FRAMER_CHECKSUM_EN
    logic [7:0]                 csum_q;
`endif

    logic commit;
    logic timeout_hit;
    logic wd_expired;

    assign commit      = rx_valid && (state_q == ST_TRAILER) && (rx_byte == EOF_BYTE);
    // A byte arriving on the timeout cycle takes priority over the timeout
    assign timeout_hit = !rx_valid && (state_q != ST_HUNT) && (idle_q == TO_LAST);

    link_watchdog #(
        .LIMIT(WATCHDOG_CYCLES)
    ) u_wd (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (commit),
        .expired_o(wd_expired)
    );

    // Inter-byte idle counter: only runs inside a frame, cleared by any byte
    always_comb begin
        idle_d = idle_q;
        if (rx_valid || (state_q == ST_HUNT) || timeout_hit) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + TO_ONE;
        end
    end

    // Idle counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    // Framing FSM with registered outputs; commit is written last so it wins over watchdog expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_HUNT;
            idx_q     <= '0;
            shadow_q  <= '0;
            payload_q <= '0;
            pv_q      <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            ad_q      <= '0;
            link_q    <= 1'b0;
            fe_q      <= 1'b0;
            ec_q      <= '0;
`ifdef PACKET_FRAMER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            pv_q <= 1'b0;
            fe_q <= 1'b0;
            if (wd_expired) begin
                link_q <= 1'b0;
                x_q    <= '0;
                y_q    <= '0;
            end
            if (rx_valid) begin
                case (state_q)
                    ST_HUNT: begin
                        if (rx_byte == SOF_BYTE) begin
                            state_q <= ST_PAYLOAD;
                            idx_q   <= '0;
`ifdef PACKET_FRAMER_CHECKSUM_EN
                            csum_q  <= '0;
`endif
                        end
                    end
                    ST_PAYLOAD: begin
                        shadow_q[{idx_q, 3'b000} +: 8] <= rx_byte;
`ifdef PACKET_FRAMER_CHECKSUM_EN
                        csum_q <= csum_q ^ rx_byte;
`endif
                        if (idx_q == IDX_LAST) begin
                            state_q <= AFTER_PAYLOAD;
                        end else begin
                            idx_q <= idx_q + IDX_ONE;
                        end
                    end
`ifdef PACKET_FRAMER_CHECKSUM_EN
                    ST_CHECK: begin
                        if (rx_byte == csum_q) begin
                            state_q <= ST_TRAILER;
                        end else begin
                            fe_q    <= 1'b1;
                            ec_q    <= sat_inc8(ec_q);
                            state_q <= ST_HUNT;
                        end
                    end
`endif
                    ST_TRAILER: begin
                        if (rx_byte == EOF_BYTE) begin
                            payload_q <= shadow_q;
                            x_q       <= shadow_q[XDIR_LSB +: XDIR_W];
                            y_q       <= shadow_q[YDIR_LSB +: YDIR_W];
                            ad_q      <= shadow_q[ADD_LSB +: ADD_W];
                            link_q    <= 1'b1;
                            pv_q      <= 1'b1;
                            state_q   <= ST_HUNT;
                        end else begin
                            fe_q <= 1'b1;
                            ec_q <= sat_inc8(ec_q);
                            if (rx_byte == SOF_BYTE) begin
                                state_q <= ST_PAYLOAD;
                                idx_q   <= '0;
`ifdef PACKET_FRAMER_CHECKSUM_EN
                                csum_q  <= '0;
`endif
                            end else begin
                                state_q <= ST_HUNT;
                            end
                        end
                    end
                    default: state_q <= ST_HUNT;
                endcase
            end else if (timeout_hit) begin
                fe_q    <= 1'b1;
                ec_q    <= sat_inc8(ec_q);
                state_q <= ST_HUNT;
            end
        end
    end

    assign payload        = payload_q;
    assign payload_valid  = pv_q;
    assign xDir           = x_q;
    assign yDir           = y_q;
    assign additionalData = ad_q;
    assign link_ok        = link_q;
    assign frame_err      = fe_q;
    assign err_count      = ec_q;
    assign state_o        = state_q;

endmodule
